// File: rtl/speed_cmd_pkg.sv
// Shared command-word constants and controller state encoding for the speed-switch path.
package speed_cmd_pkg;

    localparam logic [15:0] CMD_FAST = 16'hC891;
    localparam logic [15:0] CMD_SLOW = 16'hC894;
    localparam logic [15:0] CMD_IDLE = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    function automatic logic [15:0] cmd_code(input logic fast);
        return fast ? CMD_FAST : CMD_SLOW;
    endfunction

endpackage

// File: rtl/speed_cmd_issuer.sv
// Issues a fast/slow speed command word for HOLD_CYC cycles, then waits for matching speed_fb.
// Optional build macro SPEED_CMD_RETRY_EN re-issues the command on confirmation timeout.
module speed_cmd_issuer
    import speed_cmd_pkg::*;
#(
    parameter int unsigned HOLD_CYC    = 4,
    parameter int unsigned ACK_TIMEOUT = 240,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        clk_24m,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_fast,
    input  logic        speed_fb,
    output logic [15:0] cmd,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_MAX = (HOLD_CYC > ACK_TIMEOUT) ? HOLD_CYC : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    if (HOLD_CYC < 1 || ACK_TIMEOUT < 1 || MAX_RETRY > 255) begin : g_param_chk
        $error("speed_cmd_issuer: parameter out of range");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fast_q, fast_d;
    logic [15:0]       cmd_d;
    logic              ready_d, busy_d, done_d, err_d;

`ifdef SPEED_CMD_RETRY_EN
    localparam int unsigned RTY_W = $clog2(MAX_RETRY) + 1;
    logic [RTY_W-1:0]  retry_q, retry_d;
`endif

    // Next state and next registered outputs; one counter times both hold and ack windows.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fast_d  = fast_q;
        cmd_d   = CMD_IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef SPEED_CMD_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    fast_d  = req_fast;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    cmd_d   = cmd_code(req_fast);
                    state_d = DRIVE;
`ifdef SPEED_CMD_RETRY_EN
                    retry_d = '0;
`endif
                end else begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(ACK_TIMEOUT - 1);
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    cmd_d = cmd_code(fast_q);
                end
            end
            CHECK: begin
                if (speed_fb == fast_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
`ifdef SPEED_CMD_RETRY_EN
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RTY_W'(1);
                        cnt_d   = CNT_W'(HOLD_CYC - 1);
                        cmd_d   = cmd_code(fast_q);
                        state_d = DRIVE;
                    end else begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
`else
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_24m or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fast_q    <= 1'b0;
            cmd       <= CMD_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fast_q    <= fast_d;
            cmd       <= cmd_d;
            req_ready <= ready_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

`ifdef SPEED_CMD_RETRY_EN
    always_ff @(posedge clk_24m or negedge rstn) begin
        if (!rstn) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

endmodule

// File: tb/tb_speed_cmd_issuer.sv
// Scoreboard bench for speed_cmd_issuer with a speed-switch receiver model.
// Honours SPEED_CMD_RETRY_EN to select the expected number of attempts.
module tb_speed_cmd_issuer;

    localparam int H = 4;
    localparam int A = 16;
    localparam int R = 2;
`ifdef SPEED_CMD_RETRY_EN
    localparam int ATT = R + 1;
`else
    localparam int ATT = 1;
`endif

    typedef struct {
        bit fast;
        bit err;
        int bursts;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic        clk_24m = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_fast = 1'b0;
    logic        speed_fb = 1'b0;
    logic        req_ready, busy, done, err;
    logic [15:0] cmd;

    int rx_from   = 0;   // burst number (1-based) from which the receiver responds; 0 = never
    int rx_start  = 0;
    int rx_bursts = 0;
    bit rx_prev_nz = 1'b0;
    bit spd_model  = 1'b0;

    speed_cmd_issuer #(
        .HOLD_CYC   (H),
        .ACK_TIMEOUT(A),
        .MAX_RETRY  (R)
    ) dut (
        .clk_24m  (clk_24m),
        .rstn     (rstn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_fast (req_fast),
        .speed_fb (speed_fb),
        .cmd      (cmd),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk_24m = ~clk_24m;

    function automatic logic [15:0] code(input bit f);
        return f ? 16'hC891 : 16'hC894;
    endfunction

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endfunction

    // Receiver model: latches the commanded speed one edge after seeing the word.
    initial forever begin
        bit rise;
        int n;
        @(posedge clk_24m);
        rise = (cmd != 16'h0000) && !rx_prev_nz;
        n = rx_bursts + (rise ? 1 : 0);
        rx_bursts  = n;
        rx_prev_nz = (cmd != 16'h0000);
        if (rx_from != 0 && (n - rx_start) >= rx_from) begin
            if (cmd == 16'hC891) speed_fb <= 1'b1;
            else if (cmd == 16'hC894) speed_fb <= 1'b0;
        end
    end

    // Reference: attempt k succeeds if speed already matches or the receiver answers that burst.
    task automatic push_exp(input bit f);
        exp_t e;
        int k;
        if (spd_model == f) k = 1;
        else if (rx_from == 0) k = 1000;
        else k = rx_from;
        e.fast = f;
        if (k <= ATT) begin
            e.err = 1'b0;
            e.bursts = k;
            e.lat = (k - 1) * (H + A) + H + 1;
            spd_model = f;
        end else begin
            e.err = 1'b1;
            e.bursts = ATT;
            e.lat = ATT * (H + A);
        end
        sb.push_back(e);
    endtask

    // Monitor: latency counted in samples from the first busy sample to the done sample.
    initial begin
        bit in_txn = 1'b0;
        bit post_done = 1'b0;
        bit prev_nz = 1'b0;
        bit legal;
        int mlat = 0;
        int mbursts = 0;
        exp_t e;
        forever begin
            @(negedge clk_24m);
            if (!rstn) begin
                in_txn = 1'b0;
                post_done = 1'b0;
                prev_nz = 1'b0;
            end else begin
                chk("ready_vs_busy", int'(req_ready), int'(!busy));
                if (post_done) begin
                    chk("idle_after_done", int'(busy), 0);
                    post_done = 1'b0;
                end
                if (busy && !in_txn) begin
                    in_txn = 1'b1;
                    mlat = 0;
                    mbursts = 0;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_accept: busy=1 with no request pending");
                    end
                end else if (in_txn) begin
                    mlat++;
                end
                legal = (cmd == 16'h0000) || (in_txn && sb.size() > 0 && cmd == code(sb[0].fast));
                total++;
                if (!legal) begin
                    bad++;
                    $display("FAIL cmd_value: got %04h, want 0000 or target code", cmd);
                end
                if (cmd != 16'h0000 && !prev_nz) mbursts++;
                prev_nz = (cmd != 16'h0000);
                if (done) begin
                    if (!in_txn || sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_done: done=1 with no transaction expected");
                    end else begin
                        e = sb.pop_front();
                        chk("done_err", int'(err), int'(e.err));
                        chk("done_bursts", mbursts, e.bursts);
                        chk("done_latency", mlat, e.lat);
                        chk("busy_at_done", int'(busy), 1);
                    end
                    in_txn = 1'b0;
                    post_done = 1'b1;
                end else begin
                    chk("err_without_done", int'(err), 0);
                end
            end
        end
    end

    task automatic issue(input bit f, input int from);
        int w = 0;
        @(negedge clk_24m);
        while (!req_ready && w < 1000) begin
            @(negedge clk_24m);
            w++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL issue_wait: req_ready stuck at 0");
            return;
        end
        rx_from  = from;
        rx_start = rx_bursts;
        push_exp(f);
        req_valid = 1'b1;
        req_fast  = f;
        @(posedge clk_24m);
        #1;
        req_valid = 1'b0;
        req_fast  = 1'($urandom);
    endtask

    // req_valid held; req_fast toggles on each accept and is scrambled while not ready.
    task automatic held(input int n);
        int acc = 0;
        int w = 0;
        bit f = spd_model;
        req_valid = 1'b1;
        while (acc < n && w < 2000) begin
            @(negedge clk_24m);
            w++;
            if (req_ready) begin
                f = ~f;
                rx_from  = 1;
                rx_start = rx_bursts;
                req_fast = f;
                push_exp(f);
                @(posedge clk_24m);
                #1;
                chk("held_accept", int'(busy), 1);
                acc++;
            end else begin
                req_fast = 1'($urandom);
            end
        end
        req_valid = 1'b0;
        if (acc < n) begin
            total++;
            bad++;
            $display("FAIL held_timeout: accepted %0d of %0d", acc, n);
        end
    endtask

    initial begin
        int w;
        repeat (3) @(negedge clk_24m);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk_24m);
        chk("post_rst_ready", int'(req_ready), 1);

        // Reset asserted in the middle of a drive burst.
        issue(1'b1, 0);
        @(posedge clk_24m);
        #2;
        chk("mid_drive_cmd", int'(cmd), 32'hC891);
        rstn = 1'b0;
        #1;
        chk("async_rst_cmd", int'(cmd), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_ready", int'(req_ready), 1);
        chk("async_rst_done", int'(done), 0);
        sb.delete();
        repeat (3) @(negedge clk_24m);
        rstn = 1'b1;
        repeat (2) @(negedge clk_24m);

        issue(1'b1, 1);          // fast, receiver answers: best-case latency
        issue(1'b0, 1);          // back to slow
        issue(1'b0, 0);          // already slow: completes on first check
        issue(1'b1, 0);          // receiver silent: timeout path
        issue(1'b1, 2);          // receiver answers only the second burst
        issue(1'b0, 1);
        held(6);

        for (int i = 0; i < 30; i++) begin
            issue(1'($urandom), int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 3)) @(negedge clk_24m);
        end

        w = 0;
        while ((sb.size() != 0 || !req_ready) && w < 2000) begin
            @(negedge clk_24m);
            w++;
        end
        if (sb.size() != 0 || !req_ready) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d transactions still pending", sb.size());
        end
        repeat (2) @(negedge clk_24m);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/speed_cmd_issuer.md
# speed_cmd_issuer

Command-issuing end of the speed-switch control path. Accepts a speed-change request through a valid/ready handshake and drives the 16-bit command word (16'hC891 = fast, 16'hC894 = slow) for a fixed number of cycles. It then monitors the `speed` feedback from the speed-switch receiver and confirms the change, retrying on timeout. It sits between the host/front-panel request logic and the command bus that the speed switch decodes on clk_24m.

## Interface
- HOLD_CYC, 4: cycles each command word is held on `cmd`; ≥1.
- ACK_TIMEOUT, 240: cycles to wait for matching `speed_fb` after the hold (10 µs at 24 MHz); ≥1.
- MAX_RETRY, 3: re-issues after the first attempt before error; ≥0.
- clk_24m  input  1  system clock, 24 MHz.
- rstn  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (IDLE only).
- req_fast  input  1  target speed: 1 = fast (C891), 0 = slow (C894); sampled at handshake.
- speed_fb  input  1  current speed flag from the speed-switch receiver.
- cmd  output  16  command word; 16'h0000 when not driving.
- busy  output  1  high from the accept cycle until the done cycle inclusive.
- done  output  1  one-cycle pulse at transaction end.
- err  output  1  one-cycle pulse coincident with `done` when confirmation failed.

## Operation
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - `req_ready`=1, `cmd`=0000.
  - On `req_valid`&&`req_ready`: latch target, clear retry count, load hold counter, go to DRIVE.
- DRIVE: `cmd`=target code for exactly HOLD_CYC cycles, then `cmd`=0000, load timeout counter, go to CHECK.
- CHECK:
  - Each cycle compare `speed_fb` against the target.
  - Match: pulse `done`, go to IDLE.
  - ACK_TIMEOUT cycles without a match: retry or fail (see Configuration).
- A request whose target equals the current `speed_fb` is still issued in full; it completes on the first CHECK cycle.
- Requests while `busy` are not accepted (`req_ready`=0). The requester must hold `req_valid`.
- `cmd` never carries any value other than 0000, C891 or C894.
- Counters are sized with $clog2 of their parameter plus 1. The retry counter saturates.
- Reset values: `cmd`=0000, `req_ready`=1, `busy`=0, `done`=0, `err`=0, state IDLE.

## Timing
- All outputs are registered.
- Handshake at edge N. `busy`=1 and `cmd`=code from edge N+1 through N+HOLD_CYC. `cmd`=0000 from edge N+1+HOLD_CYC.
- The receiver updates `speed` one edge after seeing `cmd`, so `speed_fb` matches at N+2 at the earliest.
- CHECK first evaluates in the cycle after the last drive cycle. Best-case `done` at edge N+2+HOLD_CYC.
- `done` is asserted for one cycle, with `busy` still 1 in that cycle. `req_ready` returns to 1 on the following edge.
- Back-to-back requests: earliest next accept is the cycle after `done`.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronous), with no `done` pulse. The transaction is lost.
- Glitch on `speed_fb` during CHECK: the first matching sample completes the transaction. No debounce.

## Configuration
- SPEED_CMD_RETRY_EN defined:
  - On timeout with retries < MAX_RETRY: increment the retry count and re-enter DRIVE, re-issuing the same code for HOLD_CYC cycles.
  - On timeout with retries = MAX_RETRY: `done`+`err`.
- SPEED_CMD_RETRY_EN undefined:
  - Single attempt; timeout gives `done`+`err` immediately.
  - MAX_RETRY is ignored and the retry counter is not built.

## Structure
- Package speed_cmd_pkg contains:
  - constants CMD_FAST=16'hC891, CMD_SLOW=16'hC894, CMD_IDLE=16'h0000;
  - the state enum (IDLE, DRIVE, CHECK).
- The speed-switch receiver imports the same package constants.
- Flat implementation. One shared down-counter serves both hold and timeout. No sub-module.

## Test plan
- Bench parameters: HOLD_CYC=4, ACK_TIMEOUT=16, MAX_RETRY=2. The receiver model sets speed one cycle after C891 and clears it after C894.
- Reset → `cmd`=0000, `req_ready`=1, `busy`=0. Assert `rstn` low mid-DRIVE → `cmd`=0000 within the same cycle, no `done`.
- Request fast with `speed_fb`=0 at edge 10 → `cmd`=C891 on edges 11–14, 0000 at 15. `done` at 16 with `err`=0.
- Request slow while `speed_fb`=0 → C894 for 4 cycles, `done` at first CHECK cycle.
- Receiver model disabled, request fast, retry enabled → 3 bursts of C891 each followed by 16 CHECK cycles, then `done`+`err`. With the macro off: 1 burst, then `done`+`err`.
- `req_valid` held continuously with alternating `req_fast` → no accept while `busy`. Each transaction starts the cycle after `req_ready` returns high.
- Model responds only on the 2nd burst (retry enabled) → two C891 bursts, `done` with `err`=0.
